seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised multiplexed seven-segment scanner for the elevator front panel. It drives DIGITS common-anode digits from a packed nibble bus: a programmable per-digit dwell, anti-ghosting blanking at each digit change, hex decode with decimal point, per-digit enable and per-digit blink. It replaces the fixed two-digit floor/countdown decoder and sits between the elevator controller and the board's `seg`/`an` pins.

## Interface
- DIGITS, 8, number of digits scanned (1..8)
- DIV, 50000, `ck` cycles per digit slot (DIV > BLANK)
- BLANK, 2000, leading cycles of each slot with all anodes off (1 <= BLANK < DIV)
- BLINK_FRAMES, 64, full scan frames per blink half-period (power of two, >= 1)
- ck  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- digit_data  input  4*DIGITS  nibble k at [4k+3:4k] is the value for digit k (0..F)
- digit_en  input  DIGITS  1 = digit k lit, 0 = digit k dark
- dp  input  DIGITS  1 = decimal point of digit k lit
- blink  input  DIGITS  1 = digit k blinks at the blink rate
- seg  output  8  segments, active low; seg[7]=dp, seg[6:0]=g..a
- an  output  DIGITS  anodes, active low, at most one bit low at any time
- frame_tick  output  1  one-cycle pulse at the start of each scan frame

## Operation
- State: prescaler p (0..DIV-1), digit index k (0..DIGITS-1), frame counter f, blink_phase bit, capture registers for the current digit.
- p increments every cycle; at DIV-1 it wraps to 0 and k advances; k wraps DIGITS-1 -> 0 (frame wrap).
- Frame wrap increments f; every BLINK_FRAMES frames blink_phase toggles. blink_phase=0 means visible.
- Slot for digit k: cycles with p in [0, BLANK-1] are blank (an all ones, seg=8'hFF). On the edge p: BLANK-1 -> BLANK, digit_data nibble k, digit_en[k], dp[k], blink[k] are sampled and held until the slot ends.
- Digit lit if sampled en=1 and not (sampled blink=1 and blink_phase=1). Lit: an[k]=0, other anode bits 1, seg[6:0]=decode(nibble), seg[7]=~dp. Dark: an all ones, seg=8'hFF.
- Decode seg[6:0]: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110.
- Input changes mid-slot do not affect the current slot; they appear on the next visit to that digit.
- DIGITS=1: k stays 0; every slot end is a frame wrap.

## Timing
- Reset (sync, any cycle, including mid-slot): p=0, k=0, f=0, blink_phase=0, an all ones, seg=8'hFF, frame_tick=0, capture registers cleared. Takes effect on the edge where rst is sampled high.
- Cycle 0 = first cycle after the last edge with rst high. Cycle 0 has p=0, k=0.
- All outputs are registered and change on the same edge as p/k. an[k] is low exactly in cycles k*DIV+BLANK .. k*DIV+DIV-1 of a frame, when lit.
- frame_tick is high only in the cycle immediately after a frame-wrap edge (p=0, k=0). It is never asserted after reset, before the first wrap.
- Frame n begins at cycle n*DIGITS*DIV.

## Test plan
- Use DIGITS=4, DIV=8, BLANK=2, BLINK_FRAMES=2 unless noted.
- Reset: rst high 3 cycles -> an=4'b1111, seg=8'hFF, frame_tick=0. After release: cycles 0-1 blank; cycle 2 shows an=4'b1110 with digit 0 decoded.
- Full scan with digit_data=16'h4321, all enabled:
  - an=1110 in cycles 2-7, 1101 in 10-15, 1011 in 18-23, 0111 in 26-31.
  - seg=F9, A4, B0, 99 respectively.
  - an=1111 in cycles 0-1, 8-9, 16-17, 24-25.
  - frame_tick high only in cycle 32.
- Decode: nibble 4'hA with dp=1 -> seg=8'h08. Nibble 9 with dp=0 -> seg=8'h90. Nibble F -> seg=8'h8E.
- Enable and mid-slot capture:
  - digit_en[1]=0 -> an[1] stays 1 and seg=8'hFF in cycles 8-15.
  - digit_data[3:0] changed 1 -> 7 at cycle 4 -> seg stays F9 through cycle 7; seg=F8 first in cycle 34.
- Blink: blink[2]=1 -> digit 2 lit in frames 0-1, dark in frames 2-3, lit in frames 4-5. Unblinked digits stay lit throughout.
- Reset mid-slot: rst high in cycle 13 -> cycle 14 an=1111, seg=FF. After release, scan restarts at digit 0 with the blank cycles first, and frame_tick is not pulsed.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: per-digit dwell with leading blanking, hex decode with
// decimal point, per-digit enable and blink. All outputs are registered.
module seg_scan_display #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLANK        = 2000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PMAX      = PW'(DIV - 1);
    localparam logic [PW-1:0] PBLANK    = PW'(BLANK);
    localparam logic [PW-1:0] PBLANK_M1 = PW'(BLANK - 1);
    localparam logic [KW-1:0] KMAX      = KW'(DIGITS - 1);
    localparam logic [FW-1:0] FMAX      = FW'(BLINK_FRAMES - 1);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b100_0000;
            4'h1: s = 7'b111_1001;
            4'h2: s = 7'b010_0100;
            4'h3: s = 7'b011_0000;
            4'h4: s = 7'b001_1001;
            4'h5: s = 7'b001_0010;
            4'h6: s = 7'b000_0010;
            4'h7: s = 7'b111_1000;
            4'h8: s = 7'b000_0000;
            4'h9: s = 7'b001_0000;
            4'hA: s = 7'b000_1000;
            4'hB: s = 7'b000_0011;
            4'hC: s = 7'b100_0110;
            4'hD: s = 7'b010_0001;
            4'hE: s = 7'b000_0110;
            default: s = 7'b000_1110;
        endcase
        return s;
    endfunction

    logic [PW-1:0]     p_q, p_d;
    logic [KW-1:0]     k_q, k_d;
    logic [FW-1:0]     f_q, f_d;
    logic              phase_q, phase_d;
    logic [3:0]        cap_nib_q, cap_nib_d;
    logic              cap_en_q, cap_en_d;
    logic              cap_dp_q, cap_dp_d;
    logic              cap_blink_q, cap_blink_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              tick_q, tick_d;

    logic              slot_end, frame_wrap, lit;
    logic [DIGITS-1:0] sel;

    always_comb begin
        slot_end   = (p_q == PMAX);
        frame_wrap = slot_end && (k_q == KMAX);

        p_d = slot_end ? '0 : p_q + 1'b1;
        k_d = k_q;
        if (slot_end) k_d = (k_q == KMAX) ? '0 : k_q + 1'b1;

        f_d     = f_q;
        phase_d = phase_q;
        if (frame_wrap) begin
            f_d = (f_q == FMAX) ? '0 : f_q + 1'b1;
            if (f_q == FMAX) phase_d = ~phase_q;
        end

        // Sample the digit's inputs on the edge leaving the blanking window; held to slot end.
        cap_nib_d   = cap_nib_q;
        cap_en_d    = cap_en_q;
        cap_dp_d    = cap_dp_q;
        cap_blink_d = cap_blink_q;
        if (p_q == PBLANK_M1) begin
            cap_nib_d   = digit_data[{k_q, 2'b00} +: 4];
            cap_en_d    = digit_en[k_q];
            cap_dp_d    = dp[k_q];
            cap_blink_d = blink[k_q];
        end

        // Outputs are computed from next state so they change on the same edge as p/k.
        lit = (p_d >= PBLANK) && cap_en_d && !(cap_blink_d && phase_d);
        sel = '0;
        sel[k_d] = 1'b1;
        an_d   = lit ? ~sel : '1;
        seg_d  = lit ? {~cap_dp_d, decode(cap_nib_d)} : 8'hFF;
        tick_d = frame_wrap;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            p_q         <= '0;
            k_q         <= '0;
            f_q         <= '0;
            phase_q     <= 1'b0;
            cap_nib_q   <= '0;
            cap_en_q    <= 1'b0;
            cap_dp_q    <= 1'b0;
            cap_blink_q <= 1'b0;
            seg_q       <= 8'hFF;
            an_q        <= '1;
            tick_q      <= 1'b0;
        end else begin
            p_q         <= p_d;
            k_q         <= k_d;
            f_q         <= f_d;
            phase_q     <= phase_d;
            cap_nib_q   <= cap_nib_d;
            cap_en_q    <= cap_en_d;
            cap_dp_q    <= cap_dp_d;
            cap_blink_q <= cap_blink_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            tick_q      <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display with DIGITS=4, DIV=8, BLANK=2,
// BLINK_FRAMES=2 (one frame = 32 cycles).
module tb_seg_scan_display;

    localparam int unsigned DIGITS = 4;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digit_data = 16'h4321;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blink = 4'h0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seg_scan_display #(
        .DIGITS       (DIGITS),
        .DIV          (8),
        .BLANK        (2),
        .BLINK_FRAMES (2)
    ) dut (
        .ck         (ck),
        .rst        (rst),
        .digit_data (digit_data),
        .digit_en   (digit_en),
        .dp         (dp),
        .blink      (blink),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 ck = ~ck;

    // Segment codes for "1234" on digits 0..3, decimal point off.
    localparam logic [7:0] SEG_4321 [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
        cyc++;
    endtask

    // Leaves the bench in cycle 0 (sampling #1 after the last edge with rst high).
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge ck);
            #1;
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    logic [3:0] dec_nib [6] = '{4'hA, 4'h9, 4'hF, 4'h0, 4'hB, 4'h6};
    logic       dec_dp  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] dec_seg [6] = '{8'h08, 8'h90, 8'h8E, 8'hC0, 8'h03, 8'h82};

    initial begin
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        int         slot, p, fr;

        // Reset state
        rst = 1'b1;
        repeat (3) begin
            @(posedge ck);
            #1;
        end
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 8'hFF);
        check("rst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        cyc = 0;

        // Full scan of 4321, all enabled
        for (int c = 0; c <= 32; c++) begin
            run_to(c);
            slot = (c / 8) % 4;
            p    = c % 8;
            if (c < 32 && p >= 2) begin
                exp_an  = ~(4'b0001 << slot);
                exp_seg = SEG_4321[slot];
            end else begin
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
            end
            check("scan_an", an, exp_an);
            check("scan_seg", seg, exp_seg);
            check("scan_tick", frame_tick, c == 32);
        end

        // Decode of digit 0 with decimal point
        for (int i = 0; i < 6; i++) begin
            digit_data = {12'h432, dec_nib[i]};
            dp         = {3'b000, dec_dp[i]};
            do_reset();
            run_to(2);
            check("decode_an", an, 4'hE);
            check("decode_seg", seg, dec_seg[i]);
        end
        digit_data = 16'h4321;
        dp         = 4'h0;

        // Digit 1 disabled stays dark for its whole slot
        digit_en = 4'b1101;
        do_reset();
        run_to(2);
        check("en_d0_an", an, 4'hE);
        for (int c = 8; c <= 15; c++) begin
            run_to(c);
            check("en_off_an", an, 4'hF);
            check("en_off_seg", seg, 8'hFF);
        end
        run_to(18);
        check("en_d2_an", an, 4'hB);
        digit_en = 4'hF;

        // Mid-slot input change only shows on the next visit
        do_reset();
        run_to(4);
        digit_data = 16'h4327;
        for (int c = 4; c <= 7; c++) begin
            run_to(c);
            check("hold_seg", seg, 8'hF9);
        end
        run_to(33);
        check("hold_blank_seg", seg, 8'hFF);
        run_to(34);
        check("next_visit_seg", seg, 8'hF8);
        check("next_visit_an", an, 4'hE);
        digit_data = 16'h4321;

        // Blink on digit 2: lit frames 0-1, dark 2-3, lit 4-5; digit 0 always lit
        blink = 4'b0100;
        do_reset();
        for (int c = 0; c < 192; c++) begin
            run_to(c);
            fr = c / 32;
            if (c % 32 == 18) begin
                if (fr == 2 || fr == 3) begin
                    check("blink_dark_an", an, 4'hF);
                    check("blink_dark_seg", seg, 8'hFF);
                end else begin
                    check("blink_lit_an", an, 4'hB);
                    check("blink_lit_seg", seg, 8'hB0);
                end
            end
            if (c % 32 == 2) check("blink_d0_an", an, 4'hE);
        end
        blink = 4'h0;

        // Reset in the middle of digit 1's slot
        do_reset();
        run_to(13);
        check("pre_rst_an", an, 4'hD);
        rst = 1'b1;
        tick();
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_seg", seg, 8'hFF);
        check("mid_rst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 32; c++) begin
            run_to(c);
            if (c < 2) check("restart_blank_an", an, 4'hF);
            if (c == 2) begin
                check("restart_an", an, 4'hE);
                check("restart_seg", seg, 8'hF9);
            end
            check("restart_tick", frame_tick, c == 32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
